// File: rtl/tick_counter_pkg.sv
// Shared types and constants for the tick-driven BCD counter and its display.
// Contents: display FSM state enum, BCD limits, active-low 7-segment codes
// in bit order {g,f,e,d,c,b,a}, and the refresh counter width.
package tick_counter_pkg;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } digit_state_t;

  localparam int unsigned REF_W = 16;

  localparam logic [3:0] BCD_MAX   = 4'd9;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low seven-segment decoder.
// Ports:
//   bcd   - 4-bit BCD digit
//   seg_c - active-low segments {g,f,e,d,c,b,a}; blank for values 10..15
module seg7_decode
  import tick_counter_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_BLANK;
    case (bcd)
      4'd0:    seg_c = SEG_0;
      4'd1:    seg_c = SEG_1;
      4'd2:    seg_c = SEG_2;
      4'd3:    seg_c = SEG_3;
      4'd4:    seg_c = SEG_4;
      4'd5:    seg_c = SEG_5;
      4'd6:    seg_c = SEG_6;
      4'd7:    seg_c = SEG_7;
      4'd8:    seg_c = SEG_8;
      4'd9:    seg_c = SEG_9;
      default: seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/tick_bcd_counter.sv
// Two-digit BCD up/down counter stepped by rising edges of a slow tick,
// with a time-multiplexed two-digit seven-segment display driver.
// Ports:
//   clk, rst           - clock, asynchronous active-low reset
//   tick_in            - slow level signal; each rising edge is one step
//   en, up, clr        - count enable, direction (1 = up), synchronous clear
//   bcd_tens, bcd_ones - current count digits (0..9)
//   wrap               - one-cycle pulse on 99->00 or 00->99
//   seg, an            - active-low segments / digit selects (an[0] = ones)
module tick_bcd_counter
  import tick_counter_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_in,
  input  logic       en,
  input  logic       up,
  input  logic       clr,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_ones,
  output logic       wrap,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_DIV - 1);

  logic             s1, s2, s3;
  logic             step;
  logic [REF_W-1:0] refresh;
  digit_state_t     state, state_next;
  logic [3:0]       digit_sel_c;
  logic [6:0]       seg_dec_c;
  logic [6:0]       seg_next;
  logic [1:0]       an_next;

  // Sync chain resets high so a tick already high at release is not a step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= tick_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign step = s2 & ~s3;

  // BCD counter; clear has priority over any step.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      wrap     <= 1'b0;
    end else if (clr) begin
      bcd_tens <= 4'd0;
      bcd_ones <= 4'd0;
      wrap     <= 1'b0;
    end else if (step && en && up) begin
      wrap <= 1'b0;
      if (bcd_ones == BCD_MAX) begin
        bcd_ones <= 4'd0;
        if (bcd_tens == BCD_MAX) begin
          bcd_tens <= 4'd0;
          wrap     <= 1'b1;
        end else begin
          bcd_tens <= bcd_tens + 4'd1;
        end
      end else begin
        bcd_ones <= bcd_ones + 4'd1;
      end
    end else if (step && en) begin
      wrap <= 1'b0;
      if (bcd_ones == 4'd0) begin
        bcd_ones <= BCD_MAX;
        if (bcd_tens == 4'd0) begin
          bcd_tens <= BCD_MAX;
          wrap     <= 1'b1;
        end else begin
          bcd_tens <= bcd_tens - 4'd1;
        end
      end else begin
        bcd_ones <= bcd_ones - 4'd1;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  // Refresh counter sets the dwell time of each digit slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh <= '0;
    end else if (refresh == REF_LAST) begin
      refresh <= '0;
    end else begin
      refresh <= refresh + REF_W'(1);
    end
  end

  // Display FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIG_ONES;
    end else begin
      state <= state_next;
    end
  end

  // Next state: toggle on the refresh terminal count only.
  always_comb begin
    state_next = state;
    if (refresh == REF_LAST) begin
      state_next = (state == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end
  end

  // Output decode for the active digit slot.
  always_comb begin
    digit_sel_c = bcd_ones;
    an_next     = 2'b10;
    if (state == DIG_TENS) begin
      digit_sel_c = bcd_tens;
      an_next     = 2'b01;
    end
    seg_next = seg_dec_c;
  end

  seg7_decode u_dec (
    .bcd   (digit_sel_c),
    .seg_c (seg_dec_c)
  );

  // Display outputs lag the state by one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an  <= 2'b10;
      seg <= SEG_0;
    end else begin
      an  <= an_next;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// Self-checking bench for tick_bcd_counter (REFRESH_DIV = 4).
module tb_tick_bcd_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_in;
  logic       en;
  logic       up;
  logic       clr;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_ones;
  logic       wrap;
  logic [6:0] seg;
  logic [1:0] an;

  tick_bcd_counter #(.REFRESH_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .tick_in  (tick_in),
    .en       (en),
    .up       (up),
    .clr      (clr),
    .bcd_tens (bcd_tens),
    .bcd_ones (bcd_ones),
    .wrap     (wrap),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int exp_val = 0;   // bench model of the count, 0..99

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int due;
    int val;
    bit wrp;
  } sb_entry_t;

  sb_entry_t sb[$];

  typedef struct {
    int reps;
    bit en;
    bit up;
    bit clr_step;
    int exp_val;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int count_now();
    return 10 * int'(bcd_tens) + int'(bcd_ones);
  endfunction

  // Scoreboard: compare due entries at the falling edge.
  always @(negedge clk) begin : sb_check
    sb_entry_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      check("sb_due_cycle", cyc, e.due);
      check("sb_count", count_now(), e.val);
      check("sb_wrap", int'(wrap), int'(e.wrp));
    end
  end

  // One tick pulse; called just after a rising edge. Expected results are
  // pushed as the pulse is driven: old value one edge before the update,
  // new value (with wrap) at the update edge, wrap low the edge after.
  task automatic tick_pulse(input int hi, input int lo, input bit clr_step);
    int c;
    int old_v;
    bit w;
    c     = cyc;
    old_v = exp_val;
    w     = 1'b0;
    if (clr_step) begin
      exp_val = 0;
    end else if (en) begin
      if (up) begin
        w       = (old_v == 99);
        exp_val = (old_v + 1) % 100;
      end else begin
        w       = (old_v == 0);
        exp_val = (old_v + 99) % 100;
      end
    end
    sb.push_back('{due: c + 2, val: old_v,   wrp: 1'b0});
    sb.push_back('{due: c + 3, val: exp_val, wrp: w});
    sb.push_back('{due: c + 4, val: exp_val, wrp: 1'b0});
    tick_in = 1'b1;
    for (int i = 0; i < hi; i++) begin
      @(posedge clk); #1;
      if (clr_step) clr = (cyc == c + 2);
    end
    clr     = 1'b0;
    tick_in = 1'b0;
    for (int i = 0; i < lo; i++) begin
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int bad;
    int t;
    logic [1:0] prev_an;
    logic [1:0] first_an;
    logic [1:0] exp_an;
    logic [6:0] exp_seg;

    vecs.push_back('{reps: 12, en: 1'b1, up: 1'b1, clr_step: 1'b0, exp_val: 12});
    vecs.push_back('{reps: 87, en: 1'b1, up: 1'b1, clr_step: 1'b0, exp_val: 99});
    vecs.push_back('{reps: 1,  en: 1'b1, up: 1'b1, clr_step: 1'b0, exp_val: 0});
    vecs.push_back('{reps: 1,  en: 1'b1, up: 1'b0, clr_step: 1'b0, exp_val: 99});
    vecs.push_back('{reps: 1,  en: 1'b1, up: 1'b0, clr_step: 1'b1, exp_val: 0});
    vecs.push_back('{reps: 5,  en: 1'b0, up: 1'b1, clr_step: 1'b0, exp_val: 0});
    vecs.push_back('{reps: 1,  en: 1'b1, up: 1'b1, clr_step: 1'b0, exp_val: 1});
    vecs.push_back('{reps: 50, en: 1'b1, up: 1'b1, clr_step: 1'b0, exp_val: 51});
    vecs.push_back('{reps: 4,  en: 1'b1, up: 1'b0, clr_step: 1'b0, exp_val: 47});

    // Reset held with tick already high.
    rst = 1'b0; tick_in = 1'b1; en = 1'b1; up = 1'b1; clr = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("reset_count", count_now(), 0);
    check("reset_wrap", int'(wrap), 0);
    check("reset_an", int'(an), 2);
    check("reset_seg", int'(seg), int'(7'b1000000));
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (count_now() != 0 || wrap) bad++;
    end
    check("no_step_at_release", bad, 0);
    @(posedge clk); #1;
    tick_in = 1'b0;
    repeat (3) begin @(posedge clk); #1; end

    // Table-driven count phases.
    foreach (vecs[k]) begin
      en = vecs[k].en;
      up = vecs[k].up;
      for (int r = 0; r < vecs[k].reps; r++) tick_pulse(4, 6, vecs[k].clr_step);
      check($sformatf("vec%0d_count", k), count_now(), vecs[k].exp_val);
    end

    // Display mux at count 47.
    @(negedge clk);
    prev_an = an;
    t = 0;
    @(negedge clk);
    while (an == prev_an && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("an_toggle_timeout", int'(t < 20), 1);
    first_an = an;
    check("an_legal", int'(first_an == 2'b10 || first_an == 2'b01), 1);
    for (int i = 0; i < 16; i++) begin
      exp_an  = (((i / 4) % 2) == 0) ? first_an : ~first_an;
      exp_seg = (exp_an == 2'b10) ? 7'b1111000 : 7'b0011001;
      check($sformatf("mux_an_%0d", i), int'(an), int'(exp_an));
      check($sformatf("mux_seg_%0d", i), int'(seg), int'(exp_seg));
      @(negedge clk);
    end

    // Reset with a step in flight: the step is lost.
    @(posedge clk); #1;
    tick_in = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("midreset_count", count_now(), 0);
    check("midreset_wrap", int'(wrap), 0);
    check("midreset_an", int'(an), 2);
    check("midreset_seg", int'(seg), int'(7'b1000000));
    exp_val = 0;
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (count_now() != 0 || wrap) bad++;
    end
    check("midreset_step_lost", bad, 0);
    tick_in = 1'b0;
    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
